// File: rtl/ws2812_frame_sequencer_if.sv
// Signal bundle between the mode logic / LED shift register and the WS2812B frame sequencer.
// The frameCount field exists only when FRAME_COUNT_EN is defined.
interface ws2812_frame_sequencer_if;
  logic go;
  logic serialBit;
  logic load;
  logic shift;
  logic dout;
  logic busy;
  logic frameDone;
`ifdef FRAME_COUNT_EN
  logic [15:0] frameCount;
`endif

  modport master (
    output go,
    output serialBit,
    input  load,
    input  shift,
    input  dout,
    input  busy,
    input  frameDone
`ifdef FRAME_COUNT_EN
    ,input frameCount
`endif
  );

  modport slave (
    input  go,
    input  serialBit,
    output load,
    output shift,
    output dout,
    output busy,
    output frameDone
`ifdef FRAME_COUNT_EN
    ,output frameCount
`endif
  );
endinterface

// File: rtl/ws2812_frame_sequencer.sv
// Sequences a NUM_BITS shift register onto a WS2812B data line: LOAD, NUM_BITS bit slots, RET latch gap.
// Optional frame counter output enabled by defining FRAME_COUNT_EN.
module ws2812_frame_sequencer #(
  parameter int unsigned NUM_BITS = 96,
  parameter int unsigned BIT_CYC  = 125,
  parameter int unsigned T0H_CYC  = 40,
  parameter int unsigned T1H_CYC  = 80,
  parameter int unsigned RET_CYC  = 5000
) (
  input logic clk,
  input logic reset,
  ws2812_frame_sequencer_if.slave bus
);

  localparam int unsigned CYC_MAX = (BIT_CYC > RET_CYC) ? BIT_CYC : RET_CYC;
  localparam int unsigned CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
  localparam int unsigned BIT_W   = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, BIT, RET} seqState_t;

  seqState_t        state;
  logic [BIT_W-1:0] bitCnt;
  logic [CYC_W-1:0] cycCnt;
  logic             curBit;
  logic             loadReg;
  logic             shiftReg;
  logic             doutReg;
  logic             busyReg;
  logic             doneReg;

  logic [CYC_W-1:0] cycNext;
  logic             highBit;
  logic [CYC_W-1:0] highCyc;

  // Outputs are registered and aligned with the state they belong to, so the high
  // time is decided from the cycle about to start; in cycle 0 curBit is not yet latched.
  always_comb begin
    cycNext = cycCnt + CYC_W'(1);
    highBit = (cycCnt == '0) ? bus.serialBit : curBit;
    highCyc = highBit ? CYC_W'(T1H_CYC) : CYC_W'(T0H_CYC);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      bitCnt   <= '0;
      cycCnt   <= '0;
      curBit   <= 1'b0;
      loadReg  <= 1'b0;
      shiftReg <= 1'b0;
      doutReg  <= 1'b0;
      busyReg  <= 1'b0;
      doneReg  <= 1'b0;
    end else begin
      loadReg  <= 1'b0;
      shiftReg <= 1'b0;
      doutReg  <= 1'b0;
      doneReg  <= 1'b0;
      case (state)
        IDLE: begin
          busyReg <= 1'b0;
          if (bus.go) begin
            state   <= LOAD;
            loadReg <= 1'b1;
            busyReg <= 1'b1;
          end
        end
        LOAD: begin
          state   <= BIT;
          bitCnt  <= '0;
          cycCnt  <= '0;
          doutReg <= 1'b1;
        end
        BIT: begin
          if (cycCnt == '0) begin
            curBit <= bus.serialBit;
          end
          if (cycCnt == CYC_W'(BIT_CYC - 1)) begin
            cycCnt <= '0;
            if (bitCnt == BIT_W'(NUM_BITS - 1)) begin
              state   <= RET;
              doneReg <= (RET_CYC == 1);
            end else begin
              bitCnt  <= bitCnt + BIT_W'(1);
              doutReg <= 1'b1;
            end
          end else begin
            cycCnt   <= cycNext;
            doutReg  <= (cycNext < highCyc);
            shiftReg <= (cycNext == CYC_W'(BIT_CYC - 1));
          end
        end
        RET: begin
          if (cycCnt == CYC_W'(RET_CYC - 1)) begin
            state   <= IDLE;
            cycCnt  <= '0;
            busyReg <= 1'b0;
          end else begin
            cycCnt  <= cycNext;
            doneReg <= (cycNext == CYC_W'(RET_CYC - 1));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.load      = loadReg;
  assign bus.shift     = shiftReg;
  assign bus.dout      = doutReg;
  assign bus.busy      = busyReg;
  assign bus.frameDone = doneReg;

`ifdef FRAME_COUNT_EN
  logic [15:0] frameCnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      frameCnt <= '0;
    end else if (doneReg) begin
      frameCnt <= frameCnt + 16'd1;
    end
  end

  assign bus.frameCount = frameCnt;
`endif

endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// Self-checking bench: a frame-offset model predicts every output each cycle,
// and directed frames pin pulse counts, widths and gaps to hand-computed values.
module tb_ws2812_frame_sequencer;

  localparam int NUM_BITS  = 96;
  localparam int BIT_CYC   = 125;
  localparam int T0H_CYC   = 40;
  localparam int T1H_CYC   = 80;
  localparam int RET_CYC   = 5000;
  localparam int DATA_LEN  = NUM_BITS * BIT_CYC;
  localparam int FRAME_LEN = 1 + DATA_LEN + RET_CYC;

  logic clk = 1'b0;
  logic reset;
  ws2812_frame_sequencer_if bus();

  ws2812_frame_sequencer #(
    .NUM_BITS(NUM_BITS),
    .BIT_CYC (BIT_CYC),
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC),
    .RET_CYC (RET_CYC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Environment: the LED shift register the sequencer drives, with an override for mid-bit glitches.
  logic [NUM_BITS-1:0] pattern;
  logic [NUM_BITS-1:0] shreg = '0;
  logic                ovrEn;
  logic                ovrVal;

  always @(posedge clk) begin
    if (bus.load === 1'b1) shreg <= pattern;
    else if (bus.shift === 1'b1) shreg <= {shreg[NUM_BITS-2:0], 1'b0};
  end

  assign bus.serialBit = ovrEn ? ovrVal : shreg[NUM_BITS-1];

  // Model state: position within a frame measured in cycles from LOAD.
  bit          mValid  = 1'b0;
  bit          mActive = 1'b0;
  int          mOff    = 0;
  logic        mBit    = 1'b0;
  logic [15:0] mFrames = '0;
  bit          inBits;
  int          phase;
  logic [4:0]  expVec;
  logic [4:0]  actVec;

  // Measurements of the actual waveform.
  int cyc = 0;
  int loadCnt = 0, shiftCnt = 0, doneCnt = 0, b2bCnt = 0;
  int loadCyc = 0, doneCyc = 0, lastShiftCyc = 0, retLen = 0;
  int firstHighCyc = -1;
  int busyRun = 0, lastBusyLen = 0, highRun = 0;
  bit doneSeen = 1'b0;
  int highQ[$];

  always @(negedge clk) begin
    cyc++;
    inBits = (mOff >= 1) && (mOff <= DATA_LEN);
    phase  = (mOff - 1) % BIT_CYC;
    if (mValid) begin
      if (mActive) begin
        expVec[4] = (mOff == 0);
        expVec[3] = inBits && (phase == BIT_CYC - 1);
        expVec[2] = inBits && ((phase == 0) || (phase < (mBit ? T1H_CYC : T0H_CYC)));
        expVec[1] = 1'b1;
        expVec[0] = (mOff == FRAME_LEN - 1);
      end else begin
        expVec = 5'b00000;
      end
      actVec = {bus.load, bus.shift, bus.dout, bus.busy, bus.frameDone};
      checks++;
      if (actVec !== expVec) begin
        failures++;
        $display("[TB] FAIL cycle_outputs cyc=%0d {load,shift,dout,busy,done} actual=%b required=%b",
                 cyc, actVec, expVec);
      end
`ifdef FRAME_COUNT_EN
      checks++;
      if (bus.frameCount !== mFrames) begin
        failures++;
        $display("[TB] FAIL cycle_frameCount cyc=%0d actual=%0d required=%0d", cyc, bus.frameCount, mFrames);
      end
`endif
      if (bus.load === 1'b1) begin
        loadCnt++;
        if (doneSeen && (cyc - doneCyc == 2)) b2bCnt++;
        loadCyc = cyc;
        firstHighCyc = -1;
        highQ.delete();
      end
      if (bus.shift === 1'b1) begin
        shiftCnt++;
        lastShiftCyc = cyc;
      end
      if (bus.frameDone === 1'b1) begin
        doneCnt++;
        doneCyc = cyc;
        doneSeen = 1'b1;
        retLen = cyc - lastShiftCyc;
      end
      if (bus.busy === 1'b1) busyRun++;
      else begin
        if (busyRun > 0) lastBusyLen = busyRun;
        busyRun = 0;
      end
      if (bus.dout === 1'b1) begin
        if (highRun == 0 && firstHighCyc < 0) firstHighCyc = cyc;
        highRun++;
      end else begin
        if (highRun > 0) highQ.push_back(highRun);
        highRun = 0;
      end
    end
    // Advance the model across the coming posedge using the inputs the DUT will sample.
    if (reset === 1'b0) begin
      mValid  = 1'b1;
      mActive = 1'b0;
      mOff    = 0;
      mFrames = '0;
    end else if (!mActive) begin
      if (bus.go === 1'b1) begin
        mActive = 1'b1;
        mOff    = 0;
      end
    end else begin
      if (inBits && phase == 0) mBit = bus.serialBit;
      mOff++;
      if (mOff == FRAME_LEN) begin
        mActive = 1'b0;
        mFrames = mFrames + 16'd1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic goVal, input logic resetVal, input int holdCycles);
    bus.go = goVal;
    reset  = resetVal;
    repeat (holdCycles) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic int counterValue(input int which);
    case (which)
      0:       return loadCnt;
      1:       return shiftCnt;
      default: return doneCnt;
    endcase
  endfunction

  task automatic waitFor(input string name, input int which, input int target, input int limit);
    int n = 0;
    while (counterValue(which) < target && n < limit) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (counterValue(which) < target) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s timeout count=%0d required=%0d", name, counterValue(which), target);
    end
  endtask

  initial begin
    int altBad;
    pattern = {(NUM_BITS/2){2'b10}};
    ovrEn   = 1'b0;
    ovrVal  = 1'b0;
    applyStimulus(1'b0, 1'b0, 4);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_dout", bus.dout, 0);
    checkOutput("reset_load", bus.load, 0);
    checkOutput("reset_done", bus.frameDone, 0);
    applyStimulus(1'b0, 1'b1, 3);

    // Frame 1: alternating data, a mid-bit glitch on a 0 bit, and go pulses that must be ignored.
    applyStimulus(1'b1, 1'b1, 1);
    applyStimulus(1'b0, 1'b1, 0);
    waitFor("wait_bit5", 1, 5, 2000);
    repeat (20) begin @(posedge clk); #2; end
    ovrVal = 1'b1;
    ovrEn  = 1'b1;
    repeat (60) begin @(posedge clk); #2; end
    ovrEn  = 1'b0;
    waitFor("wait_bit50", 1, 50, 8000);
    applyStimulus(1'b1, 1'b1, 1);
    applyStimulus(1'b0, 1'b1, 0);
    waitFor("wait_last_shift", 1, 96, 8000);
    repeat (1000) begin @(posedge clk); #2; end
    applyStimulus(1'b1, 1'b1, 1);
    applyStimulus(1'b0, 1'b1, 0);
    waitFor("wait_frame1_done", 2, 1, 6000);
    repeat (3) begin @(posedge clk); #2; end
    checkOutput("f1_loads", loadCnt, 1);
    checkOutput("f1_shifts", shiftCnt, 96);
    checkOutput("f1_done", doneCnt, 1);
    checkOutput("f1_busy_len", lastBusyLen, 17001);
    checkOutput("f1_ret_len", retLen, 5000);
    checkOutput("f1_first_high_after_load", firstHighCyc - loadCyc, 1);
    checkOutput("f1_high_pulses", highQ.size(), 96);
    checkOutput("f1_high0", (highQ.size() > 0) ? highQ[0] : -1, 80);
    checkOutput("f1_high1", (highQ.size() > 1) ? highQ[1] : -1, 40);
    checkOutput("f1_glitched_bit5", (highQ.size() > 5) ? highQ[5] : -1, 40);
    altBad = 0;
    foreach (highQ[i]) if (highQ[i] != ((i % 2 == 0) ? T1H_CYC : T0H_CYC)) altBad++;
    checkOutput("f1_alternating_widths", altBad, 0);
`ifdef FRAME_COUNT_EN
    checkOutput("f1_frameCount", bus.frameCount, 1);
`endif

    // Three back-to-back frames with go held high.
    bus.go = 1'b1;
    waitFor("wait_held_frames", 2, 4, 3 * FRAME_LEN + 100);
    bus.go = 1'b0;
    repeat (5) begin @(posedge clk); #2; end
    checkOutput("held_loads", loadCnt, 4);
    checkOutput("held_shifts", shiftCnt - 96, 288);
    checkOutput("held_done", doneCnt - 1, 3);
    checkOutput("held_one_idle_gaps", b2bCnt, 2);
`ifdef FRAME_COUNT_EN
    checkOutput("held_frameCount", bus.frameCount, 4);
`endif

    // Reset while bit 40 is driving its high phase.
    applyStimulus(1'b1, 1'b1, 1);
    applyStimulus(1'b0, 1'b1, 0);
    waitFor("wait_bit40", 1, 384 + 40, 6000);
    repeat (30) begin @(posedge clk); #2; end
    checkOutput("mid_dout_high", bus.dout, 1);
    checkOutput("mid_busy_high", bus.busy, 1);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("rst_dout", bus.dout, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_shift", bus.shift, 0);
`ifdef FRAME_COUNT_EN
    checkOutput("rst_frameCount", bus.frameCount, 0);
`endif
    applyStimulus(1'b0, 1'b1, 10);
    checkOutput("post_rst_idle_busy", bus.busy, 0);
    checkOutput("post_rst_loads", loadCnt, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ws2812_frame_sequencer.md
Name: ws2812_frame_sequencer

Overview:
- Controller that sequences the 96-bit LED shift register into a WS2812B serial frame for a 4-LED strip.
- On `go` it pulses `load` into the shift register, then for each bit:
  - reads the shift register MSB (`serialBit`),
  - drives the WS2812B high/low waveform on `dout`,
  - strobes `shift` to advance to the next bit.
- After 96 bits it holds the line low for the RET latch period, then flags `frameDone`.
- Sits between the mode logic (which supplies `go`) and the shift register / output pin.

Parameters:
- NUM_BITS, 96, bits per frame (24 per LED x 4 LEDs).
- BIT_CYC, 125, clk cycles per data bit (1.25 us at 100 MHz).
- T0H_CYC, 40, high time for a 0 bit (0.40 us).
- T1H_CYC, 80, high time for a 1 bit (0.80 us).
- RET_CYC, 5000, low time after the frame (50 us).
- Constraints: 0 < T0H_CYC < T1H_CYC < BIT_CYC; NUM_BITS >= 1; RET_CYC >= 1.

Ports:
- clk  input  1  system clock (100 MHz).
- reset  input  1  synchronous, active-low reset; 0 = reset, sampled on posedge clk.
- go  input  1  frame request; sampled only in IDLE.
- serialBit  input  1  current MSB of the shift register.
- load  output  1  one-cycle strobe: shift register captures its load value.
- shift  output  1  one-cycle strobe: shift register advances one bit.
- dout  output  1  WS2812B data line.
- busy  output  1  high from LOAD through the end of RET.
- frameDone  output  1  one-cycle pulse at the end of RET.

Behaviour:
- All outputs are registered. Reset (reset==0 at posedge) values:
  - state=IDLE; `load`, `shift`, `dout`, `busy`, `frameDone` = 0;
  - bit counter and cycle counter = 0.
- Reset wins over every other event, including mid-bit and mid-RET. `dout` is 0 in the cycle after reset is sampled.
- IDLE:
  - `dout`=0, `busy`=0.
  - If go==1, go to LOAD next cycle.
- LOAD (1 cycle):
  - `load`=1, `busy`=1.
  - Next state BIT, with bitCnt=0 and cycCnt=0.
- BIT (BIT_CYC cycles per bit):
  - At cycCnt==0, latch `serialBit` into `curBit`; `curBit` is held for the whole bit.
  - `dout`=1 while cycCnt < (curBit ? T1H_CYC : T0H_CYC), else 0.
  - At cycCnt==BIT_CYC-1:
    - `shift`=1 for that cycle;
    - cycCnt returns to 0;
    - if bitCnt==NUM_BITS-1, go to RET; otherwise bitCnt increments.
  - The first `dout` high occurs 2 cycles after `go` is sampled.
  - `shift` pulses exactly NUM_BITS times per frame. The final shift is harmless.
- RET (RET_CYC cycles):
  - `dout`=0.
  - On the last cycle, `frameDone`=1 and the next state is IDLE; `busy` drops with the transition to IDLE.
- `go` outside IDLE is ignored and not queued.
- If `go` is held high, frames run back-to-back: IDLE lasts 1 cycle, then LOAD.
- Counter widths: cycCnt is wide enough for max(BIT_CYC, RET_CYC)-1 and is reused in RET. bitCnt is clog2(NUM_BITS) wide. No wrap occurs within the legal ranges.
- `load` and `shift` are never asserted in the same cycle.
- Total frame length from LOAD to frameDone: 1 + NUM_BITS*BIT_CYC + RET_CYC cycles (17001 with defaults).

Optional Feature:
- Macro: FRAME_COUNT_EN.
- Defined:
  - adds output `frameCount [15:0]`, reset to 0;
  - increments in the cycle after each `frameDone` pulse;
  - wraps 16'hFFFF -> 16'h0000.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then go=1 for 1 cycle:
  - `load` pulses exactly once, 1 cycle after go is sampled;
  - `busy`=1 for 1+96*125+5000 = 17001 cycles;
  - `frameDone` pulses once; 96 `shift` pulses spaced 125 cycles apart.
- serialBit alternating 1,0,1,0...: `dout` high pulses measure 80, 40, 80, 40... cycles, each within a 125-cycle bit period. The RET low period measures exactly 5000 cycles.
- serialBit toggled mid-bit (cycle 20 of a 0 bit): the high pulse stays 40 cycles, because the bit was latched at cycCnt==0.
- go held high for 3 frames: exactly 1 IDLE cycle between `frameDone` and the next `load`. Pulses seen: 3 `frameDone`, 288 `shift`.
- go pulsed during BIT and during RET: ignored; no extra `load`.
- reset driven to 0 at bit 40, cycle 30 (dout high):
  - next cycle `dout`=0 and `busy`=0, state IDLE;
  - with FRAME_COUNT_EN, `frameCount` returns to 0.
  - With FRAME_COUNT_EN and after 2 complete frames (no reset), `frameCount`=2.
